// File: rtl/hansen_mem_arbiter.sv
// Three-master arbiter for the single-port SoC RAM: fixed priority with age
// promotion, bounded locked bursts and a one-deep read-return pipeline.
`timescale 1ns/1ps
module hansen_mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int AGE_MAX   = 8,
  parameter int MAX_BURST = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [2:0]      lock,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  output logic            ram_we,
  output logic            ram_re,
  input  logic [DW-1:0]   ram_rdata,
  output logic [1:0]      owner,
  output logic            starve_evt
);
  localparam int AGE_W   = ($clog2(AGE_MAX + 1) > 4) ? $clog2(AGE_MAX + 1) : 4;
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  typedef enum logic {OPEN, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [1:0]         lock_owner, lock_owner_nxt;
  logic [BURST_W-1:0] burst_cnt, burst_cnt_nxt;
  logic               rel_vld, rel_vld_nxt;
  logic [1:0]         rel_port, rel_port_nxt;
  logic [AGE_W-1:0]   age [3];

  logic [AW-1:0] addr_a  [3];
  logic [DW-1:0] wdata_a [3];

  logic [2:0] rel_bit, cand, starved, gnt_int;
  logic [1:0] win;
  logic       win_vld, starve_raw;

  logic       vld_p0;
  logic [1:0] rd_idx_p0;

  for (genvar g = 0; g < 3; g++) begin : g_unpack
    assign addr_a[g]  = addr[g*AW +: AW];
    assign wdata_a[g] = wdata[g*DW +: DW];
  end

  // Arbitration: the release mask only bites when someone else is waiting.
  always_comb begin
    rel_bit    = 3'b000;
    if (rel_vld) rel_bit[rel_port] = 1'b1;
    cand       = req;
    if (rel_vld && ((req & ~rel_bit) != 3'b000)) cand = req & ~rel_bit;
    for (int i = 0; i < 3; i++) starved[i] = cand[i] && (age[i] == AGE_W'(AGE_MAX));
    win        = 2'd0;
    win_vld    = 1'b0;
    starve_raw = 1'b0;
    if (state == LOCKED) begin
      win     = lock_owner;
      win_vld = req[lock_owner];
    end else if (starved != 3'b000) begin
      win_vld    = 1'b1;
      starve_raw = 1'b1;
      win        = starved[0] ? 2'd0 : (starved[1] ? 2'd1 : 2'd2);
    end else if (cand != 3'b000) begin
      win_vld = 1'b1;
      win     = cand[0] ? 2'd0 : (cand[1] ? 2'd1 : 2'd2);
    end
    gnt_int = 3'b000;
    if (win_vld) gnt_int[win] = 1'b1;
  end

  always_comb begin
    state_nxt      = state;
    lock_owner_nxt = lock_owner;
    burst_cnt_nxt  = burst_cnt;
    rel_vld_nxt    = 1'b0;
    rel_port_nxt   = rel_port;
    if (state == OPEN) begin
      if (win_vld && lock[win]) begin
        state_nxt      = LOCKED;
        lock_owner_nxt = win;
        burst_cnt_nxt  = BURST_W'(1);
      end
    end else begin
      if (!req[lock_owner] || !lock[lock_owner]) begin
        state_nxt     = OPEN;
        burst_cnt_nxt = '0;
      end else if (burst_cnt == BURST_W'(MAX_BURST - 1)) begin
        state_nxt     = OPEN;
        burst_cnt_nxt = '0;
        rel_vld_nxt   = 1'b1;
        rel_port_nxt  = lock_owner;
      end else begin
        burst_cnt_nxt = burst_cnt + BURST_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= OPEN;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_owner <= 2'd0;
      burst_cnt  <= '0;
      rel_vld    <= 1'b0;
      rel_port   <= 2'd0;
      for (int i = 0; i < 3; i++) age[i] <= '0;
    end else begin
      lock_owner <= lock_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
      rel_vld    <= rel_vld_nxt;
      rel_port   <= rel_port_nxt;
      for (int i = 0; i < 3; i++) begin
        if (gnt_int[i] || !req[i])              age[i] <= '0;
        else if (age[i] != AGE_W'(AGE_MAX))     age[i] <= age[i] + AGE_W'(1);
      end
    end
  end

  // Stage p0: read-return tracking, data arrives from the RAM one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) vld_p0 <= 1'b0;
    else        vld_p0 <= win_vld && !we[win];
  end

  always_ff @(posedge clk) begin
    rd_idx_p0 <= win;
  end

  always_comb begin
    gnt        = 3'b000;
    owner      = 2'b11;
    starve_evt = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    rvalid     = 3'b000;
    if (reset) begin
      gnt = gnt_int;
      if (win_vld) begin
        owner      = win;
        starve_evt = starve_raw;
        ram_addr   = addr_a[win];
        ram_wdata  = wdata_a[win];
        ram_we     = we[win];
        ram_re     = !we[win];
      end
      if (vld_p0) rvalid[rd_idx_p0] = 1'b1;
    end
  end

  assign rdata = ram_rdata;

endmodule

// File: tb/tb_hansen_mem_arbiter.sv
// Scoreboard bench for hansen_mem_arbiter: per-port transaction queues feed the
// DUT, expected grants and read returns are queued up front and popped on output.
`timescale 1ns/1ps
module tb_hansen_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      req, we, lock;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata, ram_wdata, ram_rdata;
  logic [AW-1:0]   ram_addr;
  logic            ram_we, ram_re, starve_evt;
  logic [1:0]      owner;

  hansen_mem_arbiter #(.AW(AW), .DW(DW), .AGE_MAX(8), .MAX_BURST(16)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .owner(owner), .starve_evt(starve_evt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16384];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[15:2]] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr[15:2]];
  end

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    bit          l;
    int          seq;
  } txn_t;
  typedef struct { int port; bit stv; } gexp_t;
  typedef struct { int port; logic [31:0] data; } rexp_t;

  txn_t  pq [3][$];
  gexp_t exp_g[$];
  rexp_t exp_rd[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic push_txn(input int p, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input bit l, input int seq);
    txn_t t;
    t.w = w; t.a = a; t.d = d; t.l = l; t.seq = seq;
    pq[p].push_back(t);
  endtask

  task automatic exp_gnt(input int p, input bit stv);
    gexp_t e;
    e.port = p; e.stv = stv;
    exp_g.push_back(e);
  endtask

  task automatic exp_read(input int p, input logic [31:0] d);
    rexp_t e;
    e.port = p; e.data = d;
    exp_rd.push_back(e);
  endtask

  task automatic drive_idle();
    req = 3'b000; we = 3'b000; lock = 3'b000; addr = '0; wdata = '0;
  endtask

  task automatic run(input int budget);
    int    n    = 0;
    int    gcnt = 0;
    int    gp, rp;
    txn_t  t;
    gexp_t ge;
    rexp_t re;
    while (n < budget &&
           (pq[0].size() + pq[1].size() + pq[2].size() + exp_rd.size()) != 0) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (pq[i].size() > 0 && pq[i][0].seq <= gcnt) begin
          req[i] = 1'b1; we[i] = pq[i][0].w; lock[i] = pq[i][0].l;
          addr[i*AW +: AW]  = pq[i][0].a;
          wdata[i*DW +: DW] = pq[i][0].d;
        end else begin
          req[i] = 1'b0; we[i] = 1'b0; lock[i] = 1'b0;
        end
      end
      @(negedge clk);
      if (gnt != 3'b000) begin
        gp = 0;
        for (int i = 2; i >= 0; i--) if (gnt[i]) gp = i;
        check("gnt_onehot", 64'($onehot(gnt)), 64'd1);
        if (exp_g.size() > 0 && pq[gp].size() > 0) begin
          ge = exp_g.pop_front();
          t  = pq[gp].pop_front();
          check("gnt_port", gp, ge.port);
          check("starve_evt", starve_evt, ge.stv);
          check("owner", owner, gp);
          check("ram_addr", ram_addr, t.a);
          check("ram_we", ram_we, t.w);
          check("ram_re", ram_re, !t.w);
          if (t.w) check("ram_wdata", ram_wdata, t.d);
          gcnt++;
        end else begin
          check("gnt_unexpected", gnt, 0);
        end
      end
      if (rvalid != 3'b000) begin
        rp = 0;
        for (int i = 2; i >= 0; i--) if (rvalid[i]) rp = i;
        check("rvalid_onehot", 64'($onehot(rvalid)), 64'd1);
        if (exp_rd.size() > 0) begin
          re = exp_rd.pop_front();
          check("rvalid_port", rp, re.port);
          check("rdata", rdata, re.data);
        end else begin
          check("rvalid_unexpected", rvalid, 0);
        end
      end
      n++;
    end
    check("drain", pq[0].size() + pq[1].size() + pq[2].size() + exp_rd.size() + exp_g.size(), 0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("idle_gnt", gnt, 0);
    check("idle_rvalid", rvalid, 0);
  endtask

  initial begin
    reset = 1'b0;
    req = 3'b111; we = 3'b111; lock = 3'b000;
    addr  = {32'h30, 32'h20, 32'h10};
    wdata = {32'h3, 32'h2, 32'h1};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_owner", owner, 2'b11);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    check("post_rst_rvalid", rvalid, 0);
    check("post_rst_gnt", gnt, 0);

    // Simultaneous writes resolve by fixed priority.
    push_txn(0, 1, 32'h10, 32'hA, 0, 0);
    push_txn(1, 1, 32'h20, 32'hB, 0, 0);
    push_txn(2, 1, 32'h30, 32'hC, 0, 0);
    exp_gnt(0, 0); exp_gnt(1, 0); exp_gnt(2, 0);
    run(20);
    check("mem_10", mem[32'h10 >> 2], 32'hA);
    check("mem_20", mem[32'h20 >> 2], 32'hB);
    check("mem_30", mem[32'h30 >> 2], 32'hC);

    // Port 2 promoted after AGE_MAX cycles behind a busy port 0.
    for (int k = 0; k < 12; k++) push_txn(0, 1, 32'h100 + 4 * k, 32'h100 + k, 0, 0);
    push_txn(2, 1, 32'h200, 32'h2222, 0, 0);
    for (int k = 0; k < 8; k++) exp_gnt(0, 0);
    exp_gnt(2, 1);
    for (int k = 0; k < 4; k++) exp_gnt(0, 0);
    run(40);

    // Locked burst of 20 capped at 16, port 1 slips in, port 0 resumes.
    for (int k = 0; k < 20; k++) push_txn(0, 1, 32'h400 + 4 * k, 32'h400 + k, (k != 19), 0);
    push_txn(1, 1, 32'h500, 32'h5555, 0, 0);
    for (int k = 0; k < 16; k++) exp_gnt(0, 0);
    exp_gnt(1, 1);
    for (int k = 0; k < 4; k++) exp_gnt(0, 0);
    run(60);
    check("mem_500", mem[32'h500 >> 2], 32'h5555);

    // Alternating back-to-back reads return in grant order.
    push_txn(1, 0, 32'h20, 32'h0, 0, 0);
    push_txn(2, 0, 32'h30, 32'h0, 0, 1);
    push_txn(1, 0, 32'h20, 32'h0, 0, 2);
    push_txn(2, 0, 32'h30, 32'h0, 0, 3);
    exp_gnt(1, 0); exp_gnt(2, 0); exp_gnt(1, 0); exp_gnt(2, 0);
    exp_read(1, 32'hB); exp_read(2, 32'hC); exp_read(1, 32'hB); exp_read(2, 32'hC);
    run(20);

    // Three-beat burst ends on lock drop; port 1 follows.
    push_txn(0, 1, 32'h600, 32'h61, 1, 0);
    push_txn(0, 1, 32'h604, 32'h62, 1, 0);
    push_txn(0, 1, 32'h608, 32'h63, 0, 0);
    push_txn(1, 1, 32'h700, 32'h77, 0, 0);
    exp_gnt(0, 0); exp_gnt(0, 0); exp_gnt(0, 0); exp_gnt(1, 0);
    run(20);

    // Reset in the middle of a locked read burst.
    @(posedge clk); #1;
    req = 3'b011; we = 3'b010; lock = 3'b001;
    addr  = {32'h0, 32'h800, 32'h20};
    wdata = {32'h0, 32'hD, 32'h0};
    @(negedge clk);
    check("lk_gnt0", gnt, 3'b001);
    @(posedge clk); #1;
    @(negedge clk);
    check("lk_gnt1", gnt, 3'b001);
    check("lk_rvalid", rvalid, 3'b001);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_owner", owner, 2'b11);
    check("mid_rst_ram_re", ram_re, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    req = 3'b010; lock = 3'b000;
    @(negedge clk);
    check("rel_gnt", gnt, 3'b010);
    check("rel_rvalid", rvalid, 0);
    check("rel_starve", starve_evt, 0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("mem_800", mem[32'h800 >> 2], 32'hD);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
